// File: rtl/tff_down_counter_pkg.sv
// rtl/tff_down_counter_pkg.sv - shared constants for the T-flip-flop down counter
// Purpose: state encoding and legal WIDTH bounds shared by the counter files.
// Ports: none (package).
package tff_down_counter_pkg;

    // FSM state encoding; busy is the state bit itself.
    localparam logic IDLE = 1'b0;
    localparam logic RUN  = 1'b1;

    // Legal range of the WIDTH parameter, checked at elaboration.
    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 16;

endpackage

// File: rtl/tff_down_counter_cell.sv
// rtl/tff_down_counter_cell.sv - toggle flip-flop cell with asynchronous active-low clear
// Purpose: one T flip-flop realised as a D flop with D = Q ^ T.
// Ports:
//   clk - clock, rising edge
//   rst - asynchronous active-low clear (Q -> 0)
//   T   - toggle input; Q inverts on the edge when high
//   Q   - cell output
module tff_cell (
    input  logic clk,
    input  logic rst,
    input  logic T,
    output logic Q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            Q <= 1'b0;
        end else begin
            Q <= Q ^ T;
        end
    end

endmodule

// File: rtl/tff_down_counter.sv
// rtl/tff_down_counter.sv - programmable down counter built from toggle flip-flop cells
// Purpose: loadable countdown timer with one-shot or periodic (auto-reload) operation
//          and a one-cycle registered terminal-count pulse.
// Ports:
//   clk         - clock, all state changes on rising edge
//   rst         - asynchronous active-low reset
//   en          - count enable
//   load        - synchronous load strobe, highest synchronous priority
//   load_val    - start/reload value, sampled when load=1
//   auto_reload - 1 = periodic, 0 = one-shot; sampled on the expiring edge
//   count       - current value (Q outputs of the T cells)
//   zero        - combinational, count == 0
//   busy        - registered, high while in RUN
//   tc          - registered terminal-count pulse, one clock wide
module tff_down_counter
    import tff_down_counter_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             zero,
    output logic             busy,
    output logic             tc
);

    generate
        if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
            $error("tff_down_counter: WIDTH out of legal range");
        end
    endgenerate

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic             state;
    logic             next_state;
    logic [WIDTH-1:0] reload_q;
    logic [WIDTH-1:0] next_reload;
    logic [WIDTH-1:0] next_count;
    logic [WIDTH-1:0] dec_count;
    logic [WIDTH-1:0] t_vec;
    logic             next_tc;
    logic             borrow;

    // Decrement via a ripple borrow chain: bit i toggles while all lower bits are 0.
    always_comb begin
        dec_count = '0;
        borrow    = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            dec_count[i] = count[i] ^ borrow;
            borrow       = borrow & ~count[i];
        end
    end

    always_comb begin
        next_count  = count;
        next_state  = state;
        next_reload = reload_q;
        next_tc     = 1'b0;
        if (load) begin
            next_count  = load_val;
            next_reload = load_val;
            next_state  = (load_val != '0) ? RUN : IDLE;
        end else if (state == RUN && en) begin
            if (count == ONE) begin
                next_tc = 1'b1;
                if (auto_reload) begin
                    next_count = reload_q;
                end else begin
                    next_count = '0;
                    next_state = IDLE;
                end
            end else begin
                next_count = dec_count;
            end
        end
    end

    // Every update, including load and reload, reaches the cells as toggles.
    assign t_vec = count ^ next_count;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_cells
            tff_cell u_cell (
                .clk (clk),
                .rst (rst),
                .T   (t_vec[i]),
                .Q   (count[i])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            reload_q <= '0;
            tc       <= 1'b0;
        end else begin
            state    <= next_state;
            reload_q <= next_reload;
            tc       <= next_tc;
        end
    end

    assign busy = (state == RUN);
    assign zero = (count == '0);

endmodule

// File: tb/tb_tff_down_counter.sv
// tb/tb_tff_down_counter.sv - directed self-checking bench for tff_down_counter
module tb_tff_down_counter;

    logic       clk;
    logic       rst;
    logic       en;
    logic       load;
    logic [2:0] load_val;
    logic       auto_reload;
    logic [2:0] count;
    logic       zero;
    logic       busy;
    logic       tc;

    int vecs;
    int errs;
    int pulses;

    tff_down_counter #(.WIDTH(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .load        (load),
        .load_val    (load_val),
        .auto_reload (auto_reload),
        .count       (count),
        .zero        (zero),
        .busy        (busy),
        .tc          (tc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0d expected=%0d", name, obs, exp);
        end
    endtask

    task automatic chk_all(input string name, input int c, input int b, input int t);
        chk({name, ".count"}, 32'(count), 32'(c));
        chk({name, ".busy"}, 32'(busy), 32'(b));
        chk({name, ".tc"}, 32'(tc), 32'(t));
        chk({name, ".zero"}, 32'(zero), 32'(c == 0));
    endtask

    int exp_seq2 [12] = '{2, 1, 3, 2, 1, 3, 2, 1, 3, 2, 1, 3};
    int exp_tc2  [12] = '{0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1};
    int en_seq3  [5]  = '{1, 0, 0, 1, 1};
    int exp_seq3 [5]  = '{6, 6, 6, 5, 4};

    initial begin
        vecs = 0;
        errs = 0;
        pulses = 0;
        rst = 1'b0;
        en = 1'b0;
        load = 1'b0;
        load_val = 3'd0;
        auto_reload = 1'b0;
        #3;
        chk_all("reset", 0, 0, 0);
        #10 rst = 1'b1;

        // one-shot countdown from 5
        tick();
        load_val = 3'd5; load = 1'b1; en = 1'b1; auto_reload = 1'b0;
        tick();
        chk_all("os_load", 5, 1, 0);
        load = 1'b0;
        for (int v = 4; v >= 1; v--) begin
            tick();
            chk_all("os_dec", v, 1, 0);
        end
        tick();
        chk_all("os_expire", 0, 0, 1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_all("os_hold0", 0, 0, 0);
        end

        // periodic mode, reload 3
        load_val = 3'd3; load = 1'b1; auto_reload = 1'b1;
        tick();
        chk_all("ar_load", 3, 1, 0);
        load = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk_all("ar_cycle", exp_seq2[i], 1, exp_tc2[i]);
            if (tc === 1'b1) pulses++;
        end
        chk("ar_pulses", 32'(pulses), 32'd4);

        // enable gating
        auto_reload = 1'b0; load_val = 3'd7; load = 1'b1; en = 1'b1;
        tick();
        chk_all("en_load", 7, 1, 0);
        load = 1'b0;
        for (int i = 0; i < 5; i++) begin
            en = en_seq3[i][0];
            tick();
            chk_all("en_gate", exp_seq3[i], 1, 0);
        end
        load_val = 3'd0; load = 1'b1;
        tick();
        chk_all("load_zero", 0, 0, 0);

        // load colliding with expiring edge
        load_val = 3'd2; load = 1'b1; en = 1'b1;
        tick();
        load = 1'b0;
        tick();
        chk_all("coll_pre", 1, 1, 0);
        load_val = 3'd6; load = 1'b1;
        tick();
        chk_all("coll_load", 6, 1, 0);
        load = 1'b0; en = 1'b0;
        tick();
        chk_all("coll_after", 6, 1, 0);

        // asynchronous reset mid-count
        load_val = 3'd5; load = 1'b1; en = 1'b1;
        tick();
        load = 1'b0;
        tick();
        chk_all("rst_pre", 4, 1, 0);
        #2 rst = 1'b0;
        #1;
        chk_all("rst_async", 0, 0, 0);
        #3 rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all("rst_after", 0, 0, 0);
        end

        // IDLE at zero with enable: no wrap
        for (int i = 0; i < 8; i++) begin
            tick();
            chk_all("idle_nowrap", 0, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
